// File: rtl/tof_seq_pkg.sv
// Shared types and widths for the ToF multi-phase depth sequencer.
package tof_seq_pkg;
    localparam int PHASE_W  = 3;
    localparam int ITIME_W  = 32;
    localparam int SETTLE_W = 16;
    localparam int WDOG_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ABORT  = 3'd5
    } seq_state_e;
endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter that saturates at zero and flags when it is empty.
module seq_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);
endmodule

// File: rtl/tof_phase_sequencer.sv
// Steps the PMD frame timing through NUM_PHASES modulation phases per depth sequence.
// Optional frame watchdog enabled by defining TOF_SEQ_TIMEOUT_EN.
module tof_phase_sequencer
    import tof_seq_pkg::*;
#(
    parameter int NUM_PHASES     = 4,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               seq_start,
    input  logic               seq_abort,
    output logic               seq_rdy,
    output logic               seq_done,
    output logic               seq_error,
    input  logic [ITIME_W-1:0] integration_time_in,
    input  logic [SETTLE_W-1:0] phase_settle,
    output logic [ITIME_W-1:0] integration_time,
    output logic [PHASE_W-1:0] phase,
    output logic [PHASE_W-1:0] buf_sel,
    output logic               frame_start,
    input  logic               frame_rdy,
    input  logic               frame_done
);
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

    seq_state_e          r_state;
    seq_state_e          w_state_next;
    logic [PHASE_W-1:0]  r_phase;
    logic [ITIME_W-1:0]  r_itime;
    logic [SETTLE_W-1:0] r_settle_val;
    logic                w_accept;
    logic                w_advance;
    logic                w_dec;
    logic                w_cnt_zero;
    logic                w_wdog_expired;

    // Reload uses the settle value captured at start so later input changes cannot leak in.
    seq_down_counter #(.W(SETTLE_W)) u_settle_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_accept | w_advance),
        .i_load_val (w_accept ? phase_settle : r_settle_val),
        .i_dec      (w_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_advance    = 1'b0;
        w_dec        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (seq_start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!w_cnt_zero) begin
                    w_dec = 1'b1;
                end else if (frame_rdy) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (frame_done) begin
                    if (r_phase == LAST_PHASE) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_advance    = 1'b1;
                        w_state_next = ST_SETTLE;
                    end
                end else if (w_wdog_expired) begin
                    w_state_next = ST_ABORT;
                end
            end
            ST_DONE:  w_state_next = ST_IDLE;
            ST_ABORT: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
        // Abort wins over everything, including a frame_done in the same cycle.
        if (seq_abort && (r_state != ST_IDLE)) begin
            w_state_next = ST_IDLE;
            w_advance    = 1'b0;
            w_dec        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase      <= '0;
            r_itime      <= '0;
            r_settle_val <= '0;
        end else if (w_accept) begin
            r_phase      <= '0;
            r_itime      <= integration_time_in;
            r_settle_val <= phase_settle;
        end else if (w_advance) begin
            r_phase      <= r_phase + PHASE_W'(1);
        end
    end

`ifdef TOF_SEQ_TIMEOUT_EN
    logic [WDOG_W-1:0] r_wdog;
    logic              r_seq_error;

    assign w_wdog_expired = (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog      <= '0;
            r_seq_error <= 1'b0;
        end else begin
            if ((w_state_next == ST_WAIT) && (r_state != ST_WAIT)) begin
                r_wdog <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wdog <= r_wdog + WDOG_W'(1);
            end
            if (w_accept) begin
                r_seq_error <= 1'b0;
            end else if (w_state_next == ST_ABORT) begin
                r_seq_error <= 1'b1;
            end
        end
    end

    assign seq_error = r_seq_error;
`else
    assign w_wdog_expired = 1'b0;
    assign seq_error      = 1'b0;
`endif

    assign seq_rdy          = (r_state == ST_IDLE);
    assign seq_done         = (r_state == ST_DONE);
    assign frame_start      = (r_state == ST_START);
    assign phase            = r_phase;
    assign buf_sel          = r_phase;
    assign integration_time = r_itime;
endmodule

// File: tb/tb_tof_phase_sequencer.sv
// Directed bench for tof_phase_sequencer with a cycle-level reference model checked every clock.
// Watchdog scenario is exercised when TOF_SEQ_TIMEOUT_EN is defined.
module tb_tof_phase_sequencer;
    localparam int NP = 4;
    localparam int TO = 1000;
`ifdef TOF_SEQ_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        seq_start, seq_abort, seq_rdy, seq_done, seq_error;
    logic [31:0] integration_time_in, integration_time;
    logic [15:0] phase_settle;
    logic [2:0]  phase, buf_sel;
    logic        frame_start, frame_rdy, frame_done;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int fs_seen = 0;
    int done_seen = 0;
    int c0, r, f, d, f0;
    bit ok;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tof_phase_sequencer #(.NUM_PHASES(NP), .TIMEOUT_CYCLES(TO)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .seq_start           (seq_start),
        .seq_abort           (seq_abort),
        .seq_rdy             (seq_rdy),
        .seq_done            (seq_done),
        .seq_error           (seq_error),
        .integration_time_in (integration_time_in),
        .phase_settle        (phase_settle),
        .integration_time    (integration_time),
        .phase               (phase),
        .buf_sel             (buf_sel),
        .frame_start         (frame_start),
        .frame_rdy           (frame_rdy),
        .frame_done          (frame_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: busy flag, settle countdown, frame pending/in-flight, pulse flags.
    bit          m_busy, m_settling, m_fs, m_wait, m_done, m_abt, m_err;
    int          m_phase, m_left, m_setval, m_wd;
    logic [31:0] m_itime;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 0; m_settling <= 0; m_fs <= 0; m_wait <= 0; m_done <= 0; m_abt <= 0;
            m_err <= 0; m_phase <= 0; m_left <= 0; m_setval <= 0; m_wd <= 0; m_itime <= '0;
        end else if (m_busy && seq_abort) begin
            m_busy <= 0; m_settling <= 0; m_fs <= 0; m_wait <= 0; m_done <= 0; m_abt <= 0;
        end else if (!m_busy) begin
            if (seq_start) begin
                m_busy <= 1; m_phase <= 0; m_itime <= integration_time_in;
                m_setval <= int'(phase_settle); m_left <= int'(phase_settle);
                m_settling <= 1; m_err <= 0;
            end
        end else if (m_done || m_abt) begin
            m_busy <= 0; m_done <= 0; m_abt <= 0;
        end else if (m_fs) begin
            m_fs <= 0; m_wait <= 1; m_wd <= 0;
        end else if (m_wait) begin
            if (frame_done) begin
                m_wait <= 0;
                if (m_phase == NP - 1) m_done <= 1;
                else begin
                    m_phase <= m_phase + 1; m_left <= m_setval; m_settling <= 1;
                end
            end else if (WD_EN) begin
                m_wd <= m_wd + 1;
                if (m_wd + 1 == TO) begin
                    m_wait <= 0; m_abt <= 1; m_err <= 1;
                end
            end
        end else if (m_settling) begin
            if (m_left > 0) m_left <= m_left - 1;
            else if (frame_rdy) begin
                m_settling <= 0; m_fs <= 1;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("seq_rdy", 32'(seq_rdy), 32'(!m_busy));
            chk("seq_done", 32'(seq_done), 32'(m_done));
            chk("seq_error", 32'(seq_error), 32'(m_err));
            chk("frame_start", 32'(frame_start), 32'(m_fs));
            chk("phase", 32'(phase), 32'(m_phase));
            chk("buf_sel", 32'(buf_sel), 32'(m_phase));
            chk("integration_time", integration_time, m_itime);
            if (frame_start) fs_seen++;
            if (seq_done) done_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fs(input int limit, output bit seen);
        int n = 0;
        while (frame_start !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        seen = (frame_start === 1'b1);
        if (!seen) chk("frame_start_seen", 32'(frame_start), 32'd1);
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (seq_done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        chk("seq_done_seen", 32'(seq_done), 32'd1);
    endtask

    task automatic frame_after(input int gap);
        repeat (gap) tick();
        frame_done = 1; tick(); frame_done = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 0; seq_start = 0; seq_abort = 0; frame_rdy = 0; frame_done = 0;
        integration_time_in = '0; phase_settle = '0;
        repeat (3) tick();
        $display("txn reset: checking reset values");
        chk("rst_seq_rdy", 32'(seq_rdy), 32'd1);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_itime", integration_time, 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        reset_n = 1;
        tick();

        $display("txn nominal: settle=10 itime=0x1000, 4 phases");
        integration_time_in = 32'h1000; phase_settle = 16'd10; frame_rdy = 1;
        d = done_seen;
        seq_start = 1; c0 = cyc; tick(); seq_start = 0;
        for (int ph = 0; ph < NP; ph++) begin
            wait_fs(300, ok);
            if (ph == 0) chk("first_fs_latency", 32'(cyc - c0), 32'd12);
            chk("fs_phase", 32'(phase), 32'(ph));
            if (ph == 1) integration_time_in = 32'h2000;
            if (ph == 2) chk("itime_latched", integration_time, 32'h1000);
            frame_after(100);
        end
        wait_done(20);
        chk("done_phase", 32'(phase), 32'd3);
        repeat (5) tick();
        chk("done_once", 32'(done_seen - d), 32'd1);
        chk("itime_held_idle", integration_time, 32'h1000);

        $display("txn blocked start: settle=5, frame_rdy low 50 cycles");
        frame_rdy = 0; phase_settle = 16'd5;
        seq_start = 1; tick(); seq_start = 0;
        chk("itime_relatched", integration_time, 32'h2000);
        f0 = fs_seen;
        repeat (56) tick();
        chk("blocked_no_fs", 32'(fs_seen - f0), 32'd0);
        frame_rdy = 1; tick();
        chk("fs_one_after_rdy", 32'(frame_start), 32'd1);

        $display("txn abort collision at phase 2 frame_done");
        frame_after(3);
        wait_fs(50, ok);
        frame_after(3);
        wait_fs(50, ok);
        chk("collision_phase_pre", 32'(phase), 32'd2);
        d = done_seen;
        repeat (3) tick();
        frame_done = 1; seq_abort = 1; tick(); frame_done = 0; seq_abort = 0;
        chk("abort_rdy", 32'(seq_rdy), 32'd1);
        chk("abort_phase", 32'(phase), 32'd2);
        repeat (5) tick();
        chk("abort_no_done", 32'(done_seen - d), 32'd0);

        $display("txn idle: seq_abort and frame_done ignored");
        seq_abort = 1; frame_done = 1; tick(); seq_abort = 0; frame_done = 0;
        tick();
        chk("idle_rdy", 32'(seq_rdy), 32'd1);
        chk("idle_phase", 32'(phase), 32'd2);

        $display("txn wait without frame_done (watchdog=%0d)", WD_EN);
        phase_settle = 16'd2;
        seq_start = 1; tick(); seq_start = 0;
        wait_fs(50, ok);
        f = cyc;
`ifdef TOF_SEQ_TIMEOUT_EN
        begin
            int n = 0;
            while (seq_error !== 1'b1 && n < 1200) begin
                tick();
                n++;
            end
        end
        chk("wd_error", 32'(seq_error), 32'd1);
        chk("wd_latency", 32'(cyc - f), 32'(TO + 1));
        tick();
        chk("wd_rdy", 32'(seq_rdy), 32'd1);
        chk("wd_error_sticky", 32'(seq_error), 32'd1);
        seq_start = 1; tick(); seq_start = 0;
        chk("wd_error_cleared", 32'(seq_error), 32'd0);
        seq_abort = 1; tick(); seq_abort = 0;
`else
        repeat (TO + 100) tick();
        chk("wait_forever_busy", 32'(seq_rdy), 32'd0);
        chk("no_error", 32'(seq_error), 32'd0);
        seq_abort = 1; tick(); seq_abort = 0;
        chk("wait_abort_rdy", 32'(seq_rdy), 32'd1);
`endif

        $display("txn reset mid-sequence during phase 1");
        integration_time_in = 32'h3000; phase_settle = 16'd3;
        seq_start = 1; tick(); seq_start = 0;
        wait_fs(50, ok);
        frame_after(3);
        wait_fs(50, ok);
        repeat (2) tick();
        d = done_seen;
        reset_n = 0;
        #2;
        chk("mid_rst_rdy", 32'(seq_rdy), 32'd1);
        chk("mid_rst_phase", 32'(phase), 32'd0);
        chk("mid_rst_buf_sel", 32'(buf_sel), 32'd0);
        chk("mid_rst_itime", integration_time, 32'd0);
        chk("mid_rst_done", 32'(seq_done), 32'd0);
        chk("mid_rst_error", 32'(seq_error), 32'd0);
        tick();
        reset_n = 1;
        tick();

        $display("txn restart after reset: settle=3 itime=0x4000");
        integration_time_in = 32'h4000;
        seq_start = 1; c0 = cyc; tick(); seq_start = 0;
        wait_fs(50, ok);
        chk("restart_latency", 32'(cyc - c0), 32'd5);
        chk("restart_phase", 32'(phase), 32'd0);
        chk("restart_itime", integration_time, 32'h4000);
        for (int ph = 0; ph < NP; ph++) begin
            if (ph > 0) wait_fs(50, ok);
            frame_after(2);
        end
        wait_done(20);
        repeat (3) tick();
        chk("restart_done_once", 32'(done_seen - d), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
